// File: rtl/i2s_slave_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : i2s_slave_transmitter
// Brief    : I2S slave serializer for 24-bit L/R PCM on external bclk/lrclk.
// Revision : 1.0
// ============================================================================
module i2s_slave_transmitter #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_status,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              l_data_en,
    input  logic              r_data_en,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    output logic              sdata,
    output logic              locked,
    output logic              sample_req,
    output logic              underrun,
    output logic [CNT_W-1:0]  bit_cnt_reg
);

    localparam int                c_BITS_W    = $clog2(DATA_W + 1);
    localparam logic [c_BITS_W-1:0] c_BITS_LOAD = c_BITS_W'(DATA_W);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic r_bclk_meta, r_bclk_sync, r_bclk_dly;
    logic r_lrclk_meta, r_lrclk_sync, r_lrclk_dly;
    logic r_fe;
    logic r_lr_prev;

    logic [DATA_W-1:0]   r_l_hold, r_r_hold, r_shift;
    logic                r_l_new, r_r_new;
    logic [c_BITS_W-1:0] r_bits_left;
    logic [CNT_W-1:0]    r_cnt;

    logic w_lr_s;
    logic w_chan_start;
    logic w_load;
    logic w_shift_en;
    logic w_counting;
    logic w_fresh;

    // Registered fe keeps lrclk (via its delay flop) aligned with the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bclk_meta  <= 1'b0;
            r_bclk_sync  <= 1'b0;
            r_bclk_dly   <= 1'b0;
            r_lrclk_meta <= 1'b0;
            r_lrclk_sync <= 1'b0;
            r_lrclk_dly  <= 1'b0;
            r_fe         <= 1'b0;
            r_lr_prev    <= 1'b0;
        end else begin
            r_bclk_meta  <= bclk;
            r_bclk_sync  <= r_bclk_meta;
            r_bclk_dly   <= r_bclk_sync;
            r_lrclk_meta <= lrclk;
            r_lrclk_sync <= r_lrclk_meta;
            r_lrclk_dly  <= r_lrclk_sync;
            r_fe         <= r_bclk_dly & ~r_bclk_sync;
            if (r_fe) begin
                r_lr_prev <= r_lrclk_dly;
            end
        end
    end

    assign w_lr_s       = r_lrclk_dly;
    assign w_chan_start = r_fe && (w_lr_s != r_lr_prev);
    assign w_fresh      = w_lr_s ? r_r_new : r_l_new;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_SYNC;
            end
            ST_SYNC: begin
                if (w_chan_start && !w_lr_s) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_load = w_chan_start;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (!enable) begin
            w_state_next = ST_IDLE;
            w_load       = 1'b0;
        end
    end

    assign locked     = (r_state == ST_RUN);
    assign w_shift_en = enable && (r_state == ST_RUN) && r_fe && !w_chan_start;
    assign w_counting = enable && (r_state != ST_IDLE);

    // Load inserts the one-bit I2S delay slot before the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_bits_left <= '0;
            sdata       <= 1'b0;
            sample_req  <= 1'b0;
        end else begin
            sample_req <= 1'b0;
            if (!enable) begin
                r_shift     <= '0;
                r_bits_left <= '0;
                sdata       <= 1'b0;
            end else if (w_load) begin
                r_shift     <= w_lr_s ? r_r_hold : r_l_hold;
                r_bits_left <= c_BITS_LOAD;
                sdata       <= 1'b0;
                sample_req  <= w_lr_s;
            end else if (w_shift_en) begin
                if (r_bits_left != '0) begin
                    sdata       <= r_shift[DATA_W-1];
                    r_shift     <= {r_shift[DATA_W-2:0], 1'b0};
                    r_bits_left <= r_bits_left - 1'b1;
                end else begin
                    sdata <= 1'b0;
                end
            end
        end
    end

    // A strobe coinciding with a load wins the flag; the load reads the old hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_l_hold <= '0;
            r_r_hold <= '0;
            r_l_new  <= 1'b0;
            r_r_new  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (l_data_en) begin
                r_l_hold <= l_data;
                r_l_new  <= 1'b1;
            end else if (w_load && !w_lr_s) begin
                r_l_new <= 1'b0;
            end
            if (r_data_en) begin
                r_r_hold <= r_data;
                r_r_new  <= 1'b1;
            end else if (w_load && w_lr_s) begin
                r_r_new <= 1'b0;
            end
            if (w_load && !w_fresh) begin
                underrun <= 1'b1;
            end else if (clear_status) begin
                underrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            bit_cnt_reg <= '0;
        end else if (!w_counting) begin
            r_cnt <= '0;
        end else if (r_fe) begin
            if (w_chan_start) begin
                bit_cnt_reg <= (r_cnt == c_CNT_MAX) ? c_CNT_MAX : r_cnt + 1'b1;
                r_cnt       <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_slave_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_slave_transmitter
// Brief    : Directed bench for i2s_slave_transmitter (bclk = 16 clk).
// Revision : 1.0
// ============================================================================
module tb_i2s_slave_transmitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear_status;
    logic        bclk;
    logic        lrclk;
    logic        l_data_en;
    logic        r_data_en;
    logic [23:0] l_data;
    logic [23:0] r_data;
    logic        sdata;
    logic        locked;
    logic        sample_req;
    logic        underrun;
    logic [7:0]  bit_cnt_reg;

    int n_cmp = 0;
    int n_err = 0;
    int req_cnt = 0;

    i2s_slave_transmitter #(.DATA_W(24), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear_status (clear_status),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .l_data_en    (l_data_en),
        .r_data_en    (r_data_en),
        .l_data       (l_data),
        .r_data       (r_data),
        .sdata        (sdata),
        .locked       (locked),
        .sample_req   (sample_req),
        .underrun     (underrun),
        .bit_cnt_reg  (bit_cnt_reg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sample_req === 1'b1) begin
            req_cnt <= req_cnt + 1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bclk period, entered just after a posedge; the load clk is the 4th clk.
    task automatic bclk_period(input logic lr, input logic inj_clr, input logic inj_l,
                               input logic [23:0] inj_val, output logic bit_out);
        bclk  = 1'b0;
        lrclk = lr;
        repeat (3) @(posedge clk);
        #1;
        if (inj_clr) clear_status = 1'b1;
        if (inj_l) begin
            l_data    = inj_val;
            l_data_en = 1'b1;
        end
        @(posedge clk);
        #1;
        clear_status = 1'b0;
        l_data_en    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bclk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bit_out = sdata;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int slot, input logic wl, input logic [23:0] lv,
                             input logic wr, input logic [23:0] rv,
                             input logic inj_clr, input logic inj_l, input logic [23:0] inj_val,
                             output logic [31:0] lcap, output logic [31:0] rcap);
        logic b;
        if (wl) begin
            l_data    = lv;
            l_data_en = 1'b1;
        end
        if (wr) begin
            r_data    = rv;
            r_data_en = 1'b1;
        end
        @(posedge clk);
        #1;
        l_data_en = 1'b0;
        r_data_en = 1'b0;
        lcap = '0;
        rcap = '0;
        for (int k = 0; k < slot; k++) begin
            bclk_period(1'b0, (k == 0) && inj_clr, (k == 0) && inj_l, inj_val, b);
            lcap = {lcap[30:0], b};
        end
        for (int k = 0; k < slot; k++) begin
            bclk_period(1'b1, 1'b0, 1'b0, 24'h0, b);
            rcap = {rcap[30:0], b};
        end
    endtask

    initial begin
        logic [31:0] lc, rc;
        logic        b, acc;
        int          r0;

        reset = 1'b1; enable = 1'b0; clear_status = 1'b0;
        bclk = 1'b1; lrclk = 1'b1;
        l_data_en = 1'b0; r_data_en = 1'b0; l_data = '0; r_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sdata",    32'(sdata),       32'd0);
        check("rst_locked",   32'(locked),      32'd0);
        check("rst_req",      32'(sample_req),  32'd0);
        check("rst_underrun", 32'(underrun),    32'd0);
        check("rst_bitcnt",   32'(bit_cnt_reg), 32'd0);

        // Enable mid-frame during the right channel: nothing until lrclk falls.
        reset = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        acc = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bclk_period(1'b1, 1'b0, 1'b0, 24'h0, b);
            acc = acc | b;
        end
        check("sync_locked", 32'(locked), 32'd0);
        check("sync_sdata",  32'(acc),    32'd0);

        // 32-bit slots, fresh data.
        r0 = req_cnt;
        run_frame(32, 1'b1, 24'hA5A5A5, 1'b1, 24'h3C3C3C, 1'b0, 1'b0, 24'h0, lc, rc);
        check("f1_left",     lc, 32'h52D2D280);
        check("f1_right",    rc, 32'h1E1E1E00);
        check("f1_locked",   32'(locked),      32'd1);
        check("f1_bitcnt",   32'(bit_cnt_reg), 32'd32);
        check("f1_underrun", 32'(underrun),    32'd0);
        check("f1_req",      32'(req_cnt - r0), 32'd1);

        // No writes: words repeat, underrun set.
        run_frame(32, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, lc, rc);
        check("f2_left",     lc, 32'h52D2D280);
        check("f2_right",    rc, 32'h1E1E1E00);
        check("f2_underrun", 32'(underrun), 32'd1);

        clear_status = 1'b1;
        @(posedge clk);
        #1;
        clear_status = 1'b0;
        check("clr_underrun", 32'(underrun), 32'd0);

        // Write coinciding with the left load.
        run_frame(32, 1'b1, 24'hA5A5A5, 1'b1, 24'h3C3C3C, 1'b0, 1'b1, 24'h123456, lc, rc);
        check("f3_left_old",  lc, 32'h52D2D280);
        check("f3_underrun",  32'(underrun), 32'd0);
        run_frame(32, 1'b0, 24'h0, 1'b1, 24'h3C3C3C, 1'b0, 1'b0, 24'h0, lc, rc);
        check("f4_left_new",  lc, 32'h091A2B00);
        check("f4_underrun",  32'(underrun), 32'd0);

        // Clear in the same clk as a left underrun: set wins.
        run_frame(32, 1'b0, 24'h0, 1'b1, 24'h3C3C3C, 1'b1, 1'b0, 24'h0, lc, rc);
        check("f5_setwins",   32'(underrun), 32'd1);
        check("f5_left_rep",  lc, 32'h091A2B00);
        clear_status = 1'b1;
        @(posedge clk);
        #1;
        clear_status = 1'b0;

        // 16-bit slots: 15 data bits survive, then the right word starts.
        run_frame(16, 1'b1, 24'hFFFFFF, 1'b1, 24'h3C3C3C, 1'b0, 1'b0, 24'h0, lc, rc);
        check("f6_left16",    lc, 32'h00007FFF);
        check("f6_right16",   rc, 32'h00001E1E);
        check("f6_bitcnt",    32'(bit_cnt_reg), 32'd16);
        check("f6_underrun",  32'(underrun),    32'd0);
        run_frame(16, 1'b1, 24'hFFFFFF, 1'b1, 24'h3C3C3C, 1'b0, 1'b0, 24'h0, lc, rc);
        check("f7_left16",    lc, 32'h00007FFF);
        check("f7_locked",    32'(locked), 32'd1);

        // Reset mid-word.
        for (int k = 0; k < 5; k++) begin
            bclk_period(1'b0, 1'b0, 1'b0, 24'h0, b);
        end
        check("pre_rst_sdata",  32'(sdata),  32'd1);
        check("pre_rst_locked", 32'(locked), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_sdata",    32'(sdata),       32'd0);
        check("mid_rst_locked",   32'(locked),      32'd0);
        check("mid_rst_underrun", 32'(underrun),    32'd0);
        check("mid_rst_bitcnt",   32'(bit_cnt_reg), 32'd0);
        check("mid_rst_req",      32'(sample_req),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bclk_period(1'b0, 1'b0, 1'b0, 24'h0, b);
        end
        check("post_rst_left_nolock", 32'(locked), 32'd0);
        for (int k = 0; k < 8; k++) begin
            bclk_period(1'b1, 1'b0, 1'b0, 24'h0, b);
        end
        check("post_rst_right_nolock", 32'(locked), 32'd0);
        bclk_period(1'b0, 1'b0, 1'b0, 24'h0, b);
        check("post_rst_lock",     32'(locked),   32'd1);
        check("post_rst_underrun", 32'(underrun), 32'd1);

        // Enable drop returns to IDLE one clk later.
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("dis_locked", 32'(locked), 32'd0);
        check("dis_sdata",  32'(sdata),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_slave_transmitter.md
# i2s_slave_transmitter

Serializes 24-bit left/right PCM samples onto an I2S data line, clocked by an externally supplied bit clock and word clock. It is the transmit counterpart of the I2S-to-PCM receiver. It lets the processed audio path drive a DAC or codec that shares the incoming bclk/lrclk, with no locally generated clocks. It sits between the output sample mux and the DAC data pin, and reports slot length and underrun status to CPU registers.

## Interface
Parameters:
- DATA_W, 24, sample width; MSB-first, left-justified in the slot
- CNT_W, 8, width of the bit-count register

Ports:
- clk  in  1  system clock; must be at least 8x bclk
- reset  in  1  asynchronous, active-high reset
- enable  in  1  audio enable from the audio_control register
- clear_status  in  1  strobe; clears the sticky underrun flag
- bclk  in  1  external I2S bit clock (asynchronous)
- lrclk  in  1  external word clock; 0 = left, 1 = right
- l_data_en  in  1  strobe; l_data is valid
- r_data_en  in  1  strobe; r_data is valid
- l_data  in  DATA_W  left sample
- r_data  in  DATA_W  right sample
- sdata  out  1  I2S serial data
- locked  out  1  high while in RUN
- sample_req  out  1  one-clk pulse when the right word is loaded (the holding pair is free)
- underrun  out  1  sticky; a channel was loaded without a fresh sample
- bit_cnt_reg  out  CNT_W  bclk falling edges counted in the last completed channel period

## Operation
- Input conditioning: bclk and lrclk each pass through a 2-FF synchronizer, then one delay flop. A bclk falling event (fe) is a 1-clk pulse when the delayed value is 1 and the synced value is 0.
- lrclk is sampled on every fe into lr_prev. An fe where lrclk_s != lr_prev is a channel start.
- Holding registers l_hold and r_hold:
  - A data_en strobe captures the data and sets the matching new flag.
  - Reset clears both registers and both flags.
- FSM states:
  - IDLE: sdata = 0, locked = 0. Moves to SYNC when enable = 1.
  - SYNC: waits for a channel start with lrclk_s = 0 (left). On it, performs the left load and moves to RUN.
  - RUN: locked = 1.
  - From any state, enable = 0 moves to IDLE on the next clk. The shift register is cleared; holding registers are kept.
- Load at a channel start:
  - shift <= hold of the new channel (lrclk_s = 0 selects l_hold, 1 selects r_hold).
  - If that channel's new flag is 0, underrun <= 1. The flag is then cleared.
  - bits_left <= DATA_W.
  - sdata <= 0 for this bclk period; this is the I2S one-bit delay slot.
  - A right load pulses sample_req for 1 clk.
- Shifting: on each fe in RUN that is not a channel start:
  - If bits_left > 0: sdata <= shift MSB, shift left by 1, decrement bits_left.
  - Otherwise sdata <= 0 (padding).
- Short slot: a channel start always reloads. Untransmitted bits are dropped. No error is flagged.
- Slot counter:
  - Counts fe events and saturates at 2^CNT_W-1.
  - At each channel start, bit_cnt_reg <= count + 1 (including the current edge) and the count restarts at 0.
  - Counting runs in SYNC and RUN.
- Simultaneous events:
  - A data_en in the same clk as a load of that channel: the load uses the old hold value, the new value is captured, and the flag ends set.
  - clear_status in the same clk as an underrun set: set wins.
- Reset values: sdata 0, locked 0, sample_req 0, underrun 0, bit_cnt_reg 0, FSM IDLE.

## Timing
- sdata changes 4 clk after the physical bclk falling edge: 2 synchronizer + 1 edge flop + 1 output register. Jitter is at most 1 clk.
- The receiver samples on the bclk rising edge. Data is stable from 4 clk after the falling edge until the next falling edge, so clk >= 8x bclk is required.
- Sample pair throughput is one per lrclk period. Upstream must present l and r before their respective channel starts.
- An enable deassert takes effect 1 clk later. A re-enable resynchronizes on the next left start. The first word after lock is always a left word.

## Test plan
- 32-bit slots (64 bclk/frame) with l = 0xA5A5A5 and r = 0x3C3C3C written each frame -> sdata carries 0 in the delay slot, then 24 bits MSB-first, then 7 zeros; bit_cnt_reg = 32; underrun stays 0; sample_req pulses once per frame.
- enable raised mid-frame while lrclk = 1 -> no data until lrclk falls; the first word sent is l_hold; locked rises at that left start.
- No write before the second frame -> the previous words repeat and underrun = 1. clear_status clears it; a clear in the same clk as a new underrun leaves it at 1.
- 16-bit slots with l = 0xFFFFFF -> 15 ones are sent after the delay slot, then the right word starts; bit_cnt_reg = 16; no hang.
- reset asserted mid-word -> all outputs 0 immediately and FSM in IDLE; after release with enable = 1, locked rises only after the next left start.
- l_data_en = 0x123456 in the exact clk of the left load -> the old value is transmitted, the next frame sends 0x123456, and no underrun is flagged.
